// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with req/ack data-memory access and stall FSM
//
// Purpose: takes EX/MEM values, performs load/store over a req/ack handshake,
// registers the MEM/WB values and stalls upstream stages while memory is busy.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   rb_v_in            store data from EX/MEM
//   result_in          ALU result: byte address for ld/st, writeback value otherwise
//   hault_in           halt marker from EX/MEM
//   to_mem_sig_in      [8]rw_en [7]lh [6]memread [5]memw [4:0]rW
//   dm_req/we/addr/wdata/ack/rdata   data-memory handshake
//   stall              combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   wb_data/rw_en/rW/hault          MEM/WB register outputs
//   dm_err             sticky access-timeout flag
module mem_access_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rb_v_in,
    input  logic [31:0]       result_in,
    input  logic              hault_in,
    input  logic [8:0]        to_mem_sig_in,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              stall,
    output logic [31:0]       wb_data,
    output logic              wb_rw_en,
    output logic [4:0]        wb_rW,
    output logic              wb_hault,
    output logic              dm_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]  wb_data_q, wb_data_d;
    logic         wb_rw_en_q, wb_rw_en_d;
    logic [4:0]   wb_rW_q, wb_rW_d;
    logic         wb_hault_q, wb_hault_d;
    logic         dm_err_q, dm_err_d;
    logic         halted_q, halted_d;

    logic        rw_en, lh, memread, memw;
    logic [4:0]  rW;
    logic        mem_op;
    logic        timeout_hit;
    logic [15:0] half;
    logic [31:0] mem_val;

    assign rw_en   = to_mem_sig_in[8];
    assign lh      = to_mem_sig_in[7];
    assign memread = to_mem_sig_in[6];
    assign memw    = to_mem_sig_in[5];
    assign rW      = to_mem_sig_in[4:0];

    assign mem_op = (memread | memw) & ~halted_q;

    // The counter already holds 1 on entry to ACCESS (the request cycle in
    // IDLE counts), so dm_req is high for exactly TIMEOUT cycles on a timeout.
    assign timeout_hit = (state_q == S_ACCESS) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Gated with rst so the request drops the instant reset asserts, even
    // while EX/MEM still presents a memory op.
    assign dm_req   = rst & (((state_q == S_IDLE) & mem_op) | (state_q == S_ACCESS));
    assign dm_we    = memw;
    assign dm_addr  = result_in[ADDR_W-1:0];
    assign dm_wdata = rb_v_in;

    // Released on the timeout cycle too, so the aborted op leaves EX/MEM on
    // the completion edge instead of being reissued.
    assign stall = dm_req & ~dm_ack & ~timeout_hit;

    // Loaded only into flops, so dm_rdata never reaches an output combinationally.
    assign half    = result_in[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    assign mem_val = memw ? result_in : (lh ? {{16{half[15]}}, half} : dm_rdata);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_rw_en_d = wb_rw_en_q;
        wb_rW_d    = wb_rW_q;
        wb_hault_d = wb_hault_q;
        dm_err_d   = dm_err_q;
        halted_d   = halted_q;
        case (state_q)
            S_IDLE: begin
                if (!mem_op) begin
                    wb_data_d  = result_in;
                    wb_rw_en_d = rw_en & ~halted_q;
                    wb_rW_d    = rW;
                    wb_hault_d = hault_in;
                    halted_d   = halted_q | hault_in;
                end else if (dm_ack) begin
                    wb_data_d  = mem_val;
                    wb_rw_en_d = rw_en;
                    wb_rW_d    = rW;
                    wb_hault_d = hault_in;
                    halted_d   = halted_q | hault_in;
                end else begin
                    state_d    = S_ACCESS;
                    cnt_d      = CNT_W'(1);
                    wb_rw_en_d = 1'b0;
                    wb_hault_d = 1'b0;
                end
            end
            S_ACCESS: begin
                if (dm_ack || timeout_hit) begin
                    wb_data_d  = dm_ack ? mem_val : 32'h0;
                    wb_rw_en_d = rw_en;
                    wb_rW_d    = rW;
                    wb_hault_d = hault_in;
                    halted_d   = halted_q | hault_in;
                    dm_err_d   = dm_err_q | ~dm_ack;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    wb_rw_en_d = 1'b0;
                    wb_hault_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wb_data_q  <= 32'h0;
            wb_rw_en_q <= 1'b0;
            wb_rW_q    <= 5'h0;
            wb_hault_q <= 1'b0;
            dm_err_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_rw_en_q <= wb_rw_en_d;
            wb_rW_q    <= wb_rW_d;
            wb_hault_q <= wb_hault_d;
            dm_err_q   <= dm_err_d;
            halted_q   <= halted_d;
        end
    end

    assign wb_data  = wb_data_q;
    assign wb_rw_en = wb_rw_en_q;
    assign wb_rW    = wb_rW_q;
    assign wb_hault = wb_hault_q;
    assign dm_err   = dm_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rb_v_in;
    logic [31:0] result_in;
    logic        hault_in;
    logic [8:0]  to_mem_sig_in;
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic [31:0] wb_data;
    logic        wb_rw_en;
    logic [4:0]  wb_rW;
    logic        wb_hault;
    logic        dm_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.ADDR_W(10), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .rb_v_in(rb_v_in), .result_in(result_in),
        .hault_in(hault_in), .to_mem_sig_in(to_mem_sig_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
        .wb_data(wb_data), .wb_rw_en(wb_rw_en), .wb_rW(wb_rW),
        .wb_hault(wb_hault), .dm_err(dm_err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] sig(input logic rw, input logic h, input logic rd,
                                       input logic wr, input logic [4:0] rd_reg);
        return {rw, h, rd, wr, rd_reg};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; rb_v_in = 32'h0; result_in = 32'h0; hault_in = 1'b0;
        to_mem_sig_in = 9'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
        #3;
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
        checks++; if ({wb_rw_en, wb_rW, wb_hault, dm_err} !== 8'h0) begin errors++; $display("FAIL reset_flags got %h exp 0", {wb_rw_en, wb_rW, wb_hault, dm_err}); end
        checks++; if ({dm_req, stall} !== 2'b00) begin errors++; $display("FAIL reset_req_stall got %b exp 00", {dm_req, stall}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        result_in = 32'h1234; to_mem_sig_in = sig(1, 0, 0, 0, 5'd5);
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;  // stray ack without request
        #1;
        checks++; if ({dm_req, stall} !== 2'b00) begin errors++; $display("FAIL alu_req_stall got %b exp 00", {dm_req, stall}); end
        cycle();
        dm_ack = 1'b0;
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_wb_data got %h exp 00001234", wb_data); end
        checks++; if ({wb_rw_en, wb_rW} !== {1'b1, 5'd5}) begin errors++; $display("FAIL alu_wb_ctrl got %h exp 25", {wb_rw_en, wb_rW}); end
    endtask

    task automatic test_load_wait();
        result_in = 32'h10; to_mem_sig_in = sig(1, 0, 1, 0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({dm_req, dm_we, stall} !== 3'b101) begin errors++; $display("FAIL load_wait%0d_req_we_stall got %b exp 101", i, {dm_req, dm_we, stall}); end
            cycle();
            checks++; if (wb_rw_en !== 1'b0) begin errors++; $display("FAIL load_wait%0d_bubble got %b exp 0", i, wb_rw_en); end
        end
        dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_ack_stall got %b exp 0", stall); end
        cycle();
        dm_ack = 1'b0; to_mem_sig_in = 9'h0;
        checks++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_wb_data got %h exp cafef00d", wb_data); end
        checks++; if ({wb_rw_en, wb_rW} !== {1'b1, 5'd7}) begin errors++; $display("FAIL load_wb_ctrl got %h exp 27", {wb_rw_en, wb_rW}); end
    endtask

    task automatic test_lh();
        result_in = 32'h12; to_mem_sig_in = sig(1, 1, 1, 0, 5'd3);
        dm_ack = 1'b1; dm_rdata = 32'h8001_7FFF;
        #1;
        checks++; if ({dm_req, stall} !== 2'b10) begin errors++; $display("FAIL lh_zero_wait got %b exp 10", {dm_req, stall}); end
        cycle();
        checks++; if (wb_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_hi got %h exp ffff8001", wb_data); end
        result_in = 32'h10;
        cycle();
        checks++; if (wb_data !== 32'h0000_7FFF) begin errors++; $display("FAIL lh_lo got %h exp 00007fff", wb_data); end
        dm_ack = 1'b0; to_mem_sig_in = 9'h0;
    endtask

    task automatic test_store();
        result_in = 32'h20; rb_v_in = 32'hA5A5_A5A5; to_mem_sig_in = sig(0, 1, 0, 1, 5'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({dm_req, dm_we, stall} !== 3'b111) begin errors++; $display("FAIL store%0d_req_we_stall got %b exp 111", i, {dm_req, dm_we, stall}); end
            checks++; if ({dm_addr, dm_wdata} !== {10'h020, 32'hA5A5_A5A5}) begin errors++; $display("FAIL store%0d_addr_data got %h/%h exp 020/a5a5a5a5", i, dm_addr, dm_wdata); end
            cycle();
        end
        dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        cycle();
        dm_ack = 1'b0; to_mem_sig_in = 9'h0;
        checks++; if ({wb_data, wb_rw_en} !== {32'h20, 1'b0}) begin errors++; $display("FAIL store_wb got %h/%b exp 00000020/0", wb_data, wb_rw_en); end
    endtask

    task automatic test_timeout();
        int  n;
        logic done;
        n = 0; done = 1'b0;
        result_in = 32'h40; dm_rdata = 32'h5555_5555; to_mem_sig_in = sig(1, 0, 1, 0, 5'd9);
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (dm_req) n++;
            if (!stall) done = 1'b1;
            cycle();
        end
        to_mem_sig_in = 9'h0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_bound got stall stuck exp release"); end
        checks++; if (n !== 64) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 64", n); end
        checks++; if ({dm_err, wb_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL timeout_err_data got %b/%h exp 1/00000000", dm_err, wb_data); end
        #1;
        checks++; if ({dm_req, stall} !== 2'b00) begin errors++; $display("FAIL timeout_release got %b exp 00", {dm_req, stall}); end
    endtask

    task automatic test_halt();
        result_in = 32'h55; hault_in = 1'b1; to_mem_sig_in = sig(1, 0, 0, 0, 5'd1);
        cycle();
        checks++; if ({wb_hault, wb_rw_en, wb_data} !== {2'b11, 32'h55}) begin errors++; $display("FAIL halt_wb got %b%b/%h exp 11/00000055", wb_hault, wb_rw_en, wb_data); end
        hault_in = 1'b0; result_in = 32'h30; rb_v_in = 32'h7; to_mem_sig_in = sig(1, 0, 0, 1, 5'd2);
        #1;
        checks++; if ({dm_req, stall} !== 2'b00) begin errors++; $display("FAIL halt_blocks_req got %b exp 00", {dm_req, stall}); end
        cycle();
        checks++; if ({wb_rw_en, wb_data} !== {1'b0, 32'h30}) begin errors++; $display("FAIL halt_pass got %b/%h exp 0/00000030", wb_rw_en, wb_data); end
    endtask

    task automatic test_reset_mid();
        to_mem_sig_in = sig(1, 0, 1, 0, 5'd4); result_in = 32'h10;
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({dm_err, wb_hault, wb_rw_en, wb_rW, wb_data} !== 39'h0) begin errors++; $display("FAIL rst_async_clear got %b%b%b/%h/%h exp all 0", dm_err, wb_hault, wb_rw_en, wb_rW, wb_data); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rst_clears_halt got %b exp 1", dm_req); end
        cycle();
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_access_stall got %b exp 1", stall); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({dm_req, stall} !== 2'b00) begin errors++; $display("FAIL mid_access_rst got %b exp 00", {dm_req, stall}); end
        @(negedge clk);
        to_mem_sig_in = 9'h0;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_lh();
        test_store();
        test_timeout();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
